// File: rtl/sd_cmd_pkg.sv
// SD command-line shared constants: FSM encoding, frame widths, CRC7 polynomial and field positions.
// Pure declarations; no latency or backpressure.
package sd_cmd_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RECV     = 3'd1;
    localparam logic [2:0] ST_CHECK    = 3'd2;
    localparam logic [2:0] ST_NOTIFY   = 3'd3;
    localparam logic [2:0] ST_WAIT_NCR = 3'd4;
    localparam logic [2:0] ST_SEND     = 3'd5;

    localparam logic [7:0] CMD_FRAME_W = 8'd48;
    localparam logic [7:0] R2_FRAME_W  = 8'd136;
    localparam logic [7:0] CRC_COVER_W = 8'd40;
    localparam logic [6:0] CRC7_POLY   = 7'h09;

    localparam int START_BIT = 47;
    localparam int TX_BIT    = 46;
    localparam int IDX_MSB   = 45;
    localparam int IDX_LSB   = 40;
    localparam int ARG_MSB   = 39;
    localparam int ARG_LSB   = 8;
    localparam int CRC_MSB   = 7;
    localparam int CRC_LSB   = 1;
    localparam int END_BIT   = 0;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), one bit per enabled cycle; clear alongside enable restarts from zero.
// Latency 1 cycle per bit; no backpressure.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       sd_clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] base;
    logic       feedback;
    logic [6:0] crc_next;

    always_comb begin
        base     = clear ? 7'h00 : crc;
        feedback = base[6] ^ bit_in;
        crc_next = {base[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            crc <= 7'h00;
        end else if (enable) begin
            crc <= crc_next;
        end else if (clear) begin
            crc <= 7'h00;
        end
    end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side CMD line: deframes/CRC-checks host commands (strobe 2 cycles after the last bit), then sends the response NCR+1 cycles after resp_ack.
// Command is held on cmd_strobe until card logic raises resp_valid; abort returns to IDLE at once.
module sd_card_cmd_responder
    import sd_cmd_pkg::*;
#(
    parameter int NCR = 2
) (
    input  logic         sd_clock,
    input  logic         reset,
    input  logic         abort,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         cmd_strobe,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         crc_error,
    input  logic         resp_valid,
    input  logic         resp_none,
    input  logic         resp_long,
    input  logic [135:0] resp_data,
    output logic         resp_ack
);

    localparam logic [7:0] NCR_CNT = 8'(NCR);

    logic [2:0]   state;
    logic [7:0]   bit_cnt;
    logic [47:0]  rx_shift;
    logic [135:0] tx_shift;
    logic         tx_long;
    logic [6:0]   rx_crc;
    logic [6:0]   tx_crc;

    logic rx_start, rx_crc_en, rx_crc_clear;
    logic tx_crc_en, tx_crc_clear, tx_bit, frame_ok;
    logic [7:0] tx_total;

    always_comb begin
        rx_start     = !abort && state == ST_IDLE && !cmd_in;
        rx_crc_clear = state == ST_IDLE;
        rx_crc_en    = rx_start || (!abort && state == ST_RECV && bit_cnt < CRC_COVER_W);
        tx_crc_clear = state != ST_WAIT_NCR && state != ST_SEND;
        tx_crc_en    = !abort && ((state == ST_WAIT_NCR && bit_cnt == NCR_CNT) ||
                                   (state == ST_SEND && bit_cnt < CRC_COVER_W));
        tx_total     = tx_long ? R2_FRAME_W : CMD_FRAME_W;
        // Short responses switch from the payload to the generated CRC after 40 bits.
        tx_bit       = tx_shift[135];
        if (state == ST_SEND && !tx_long && bit_cnt == CRC_COVER_W) begin
            tx_bit = tx_crc[6];
        end
        frame_ok = !rx_shift[START_BIT] && rx_shift[TX_BIT] && rx_shift[END_BIT] &&
                   (rx_shift[CRC_MSB:CRC_LSB] == rx_crc);
    end

    sd_crc7 u_rx_crc (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (rx_crc_clear),
        .enable   (rx_crc_en),
        .bit_in   (cmd_in),
        .crc      (rx_crc)
    );

    sd_crc7 u_tx_crc (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (tx_crc_clear),
        .enable   (tx_crc_en),
        .bit_in   (tx_shift[135]),
        .crc      (tx_crc)
    );

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= 8'd0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_long    <= 1'b0;
            cmd_out    <= 1'b1;
            cmd_oe     <= 1'b0;
            cmd_strobe <= 1'b0;
            cmd_index  <= 6'd0;
            cmd_arg    <= 32'd0;
            crc_error  <= 1'b0;
            resp_ack   <= 1'b0;
        end else begin
            crc_error <= 1'b0;
            resp_ack  <= 1'b0;
            if (abort) begin
                state      <= ST_IDLE;
                bit_cnt    <= 8'd0;
                cmd_oe     <= 1'b0;
                cmd_out    <= 1'b1;
                cmd_strobe <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!cmd_in) begin
                            rx_shift <= {rx_shift[46:0], cmd_in};
                            bit_cnt  <= 8'd1;
                            state    <= ST_RECV;
                        end
                    end
                    ST_RECV: begin
                        if (bit_cnt == CMD_FRAME_W) begin
                            state <= ST_CHECK;
                        end else begin
                            rx_shift <= {rx_shift[46:0], cmd_in};
                            bit_cnt  <= bit_cnt + 8'd1;
                        end
                    end
                    ST_CHECK: begin
                        if (frame_ok) begin
                            cmd_index  <= rx_shift[IDX_MSB:IDX_LSB];
                            cmd_arg    <= rx_shift[ARG_MSB:ARG_LSB];
                            cmd_strobe <= 1'b1;
                            state      <= ST_NOTIFY;
                        end else begin
                            crc_error <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                    ST_NOTIFY: begin
                        if (resp_valid) begin
                            resp_ack   <= 1'b1;
                            cmd_strobe <= 1'b0;
                            tx_long    <= resp_long;
                            tx_shift   <= resp_long ? resp_data : {resp_data[47:8], 96'd0};
                            bit_cnt    <= 8'd0;
                            state      <= resp_none ? ST_IDLE : ST_WAIT_NCR;
                        end
                    end
                    ST_WAIT_NCR: begin
                        if (bit_cnt == NCR_CNT) begin
                            cmd_oe   <= 1'b1;
                            cmd_out  <= tx_bit;
                            tx_shift <= {tx_shift[134:0], 1'b0};
                            bit_cnt  <= 8'd1;
                            state    <= ST_SEND;
                        end else begin
                            bit_cnt <= bit_cnt + 8'd1;
                        end
                    end
                    ST_SEND: begin
                        if (bit_cnt == tx_total) begin
                            cmd_oe  <= 1'b0;
                            cmd_out <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            cmd_out <= tx_bit;
                            if (!tx_long && bit_cnt == CRC_COVER_W) begin
                                tx_shift <= {tx_crc[5:0], 1'b1, 129'd0};
                            end else begin
                                tx_shift <= {tx_shift[134:0], 1'b0};
                            end
                            bit_cnt <= bit_cnt + 8'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Randomized bench for sd_card_cmd_responder against a polynomial-division CRC model and timing rules.
module tb_sd_card_cmd_responder;

    localparam int NCR_TB = 2;

    logic         sd_clock;
    logic         reset;
    logic         abort;
    logic         cmd_in;
    logic         cmd_out;
    logic         cmd_oe;
    logic         cmd_strobe;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic         crc_error;
    logic         resp_valid;
    logic         resp_none;
    logic         resp_long;
    logic [135:0] resp_data;
    logic         resp_ack;

    int checks = 0;
    int errors = 0;
    logic [5:0]  exp_index;
    logic [31:0] exp_arg;

    sd_card_cmd_responder #(.NCR(NCR_TB)) dut (
        .sd_clock   (sd_clock),
        .reset      (reset),
        .abort      (abort),
        .cmd_in     (cmd_in),
        .cmd_out    (cmd_out),
        .cmd_oe     (cmd_oe),
        .cmd_strobe (cmd_strobe),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .crc_error  (crc_error),
        .resp_valid (resp_valid),
        .resp_none  (resp_none),
        .resp_long  (resp_long),
        .resp_data  (resp_data),
        .resp_ack   (resp_ack)
    );

    initial begin
        sd_clock = 1'b0;
        forever #5 sd_clock = ~sd_clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // CRC7 as remainder of d * x^7 divided by x^7+x^3+1 (generator 0x89).
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic frame_ok_ref(input logic [47:0] f);
        return !f[47] && f[46] && f[0] && (f[7:1] == crc7_ref(f[47:8]));
    endfunction

    function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] body;
        body = {2'b01, idx, arg};
        return {body, crc7_ref(body), 1'b1};
    endfunction

    // Drives a frame and checks the strobe / crc_error outcome and its timing.
    task automatic recv_frame(input logic [47:0] f, input string name);
        logic ok;
        int early;
        ok = frame_ok_ref(f);
        early = 0;
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clock);
            cmd_in = f[i];
            if (cmd_strobe !== 1'b0 || crc_error !== 1'b0) early++;
        end
        @(negedge sd_clock);
        cmd_in = 1'b1;
        if (cmd_strobe !== 1'b0 || crc_error !== 1'b0) early++;
        @(negedge sd_clock);
        if (cmd_strobe !== 1'b0 || crc_error !== 1'b0) early++;
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL %s_early: strobe/crc_error seen %0d cycles before t+49, required 0", name, early);
        end
        @(negedge sd_clock);
        checks++;
        if (ok) begin
            if (cmd_strobe !== 1'b1 || crc_error !== 1'b0 || cmd_index !== f[45:40] || cmd_arg !== f[39:8]) begin
                errors++;
                $display("FAIL %s_strobe: strobe=%b err=%b idx=%h arg=%h, required strobe=1 err=0 idx=%h arg=%h",
                         name, cmd_strobe, crc_error, cmd_index, cmd_arg, f[45:40], f[39:8]);
            end
            exp_index = f[45:40];
            exp_arg   = f[39:8];
        end else begin
            if (crc_error !== 1'b1 || cmd_strobe !== 1'b0 || cmd_index !== exp_index || cmd_arg !== exp_arg) begin
                errors++;
                $display("FAIL %s_crcerr: err=%b strobe=%b idx=%h arg=%h, required err=1 strobe=0 idx=%h arg=%h",
                         name, crc_error, cmd_strobe, cmd_index, cmd_arg, exp_index, exp_arg);
            end
            @(negedge sd_clock);
            checks++;
            if (crc_error !== 1'b0 || cmd_strobe !== 1'b0) begin
                errors++;
                $display("FAIL %s_pulse: err=%b strobe=%b one cycle later, required 0 0", name, crc_error, cmd_strobe);
            end
        end
    endtask

    // kind: 0 = no response, 1 = short, 2 = long R2. Called with cmd_strobe high.
    task automatic respond(input int kind, input logic [135:0] data, input int delay,
                           input string name, output logic [135:0] got);
        logic [135:0] exp;
        int len, oe_hi, oe_early;
        got = '0;
        oe_hi = 0;
        oe_early = 0;
        for (int i = 0; i < delay; i++) begin
            @(negedge sd_clock);
            checks++;
            if (cmd_strobe !== 1'b1) begin
                errors++;
                $display("FAIL %s_hold: strobe=%b while waiting for resp_valid, required 1", name, cmd_strobe);
            end
        end
        resp_valid = 1'b1;
        resp_none  = (kind == 0);
        resp_long  = (kind == 2);
        resp_data  = data;
        @(negedge sd_clock);
        checks++;
        if (resp_ack !== 1'b1 || cmd_strobe !== 1'b0) begin
            errors++;
            $display("FAIL %s_ack: ack=%b strobe=%b, required ack=1 strobe=0", name, resp_ack, cmd_strobe);
        end
        resp_valid = 1'b0;
        resp_none  = 1'b0;
        resp_long  = 1'b0;
        resp_data  = ~data;
        if (cmd_oe !== 1'b0) oe_early++;
        for (int k = 1; k <= NCR_TB; k++) begin
            @(negedge sd_clock);
            if (cmd_oe !== 1'b0 || resp_ack !== 1'b0) oe_early++;
        end
        checks++;
        if (oe_early != 0) begin
            errors++;
            $display("FAIL %s_ncr: %0d bad cycles in NCR gap (oe or ack high), required 0", name, oe_early);
        end
        if (kind == 0) begin
            for (int k = 0; k < 60; k++) begin
                @(negedge sd_clock);
                if (cmd_oe !== 1'b0) oe_hi++;
            end
            checks++;
            if (oe_hi != 0) begin
                errors++;
                $display("FAIL %s_none: cmd_oe high %0d cycles, required 0", name, oe_hi);
            end
        end else begin
            len = (kind == 2) ? 136 : 48;
            exp = (kind == 2) ? data : {88'd0, data[47:8], crc7_ref(data[47:8]), 1'b1};
            for (int i = 0; i < len; i++) begin
                @(negedge sd_clock);
                if (cmd_oe === 1'b1) oe_hi++;
                got = {got[134:0], cmd_out};
            end
            @(negedge sd_clock);
            checks++;
            if (oe_hi != len || cmd_oe !== 1'b0 || cmd_out !== 1'b1) begin
                errors++;
                $display("FAIL %s_window: oe high %0d cycles then oe=%b out=%b, required %0d then 0 1",
                         name, oe_hi, cmd_oe, cmd_out, len);
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_bits: got %h, required %h", name, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge sd_clock);
        checks++;
        if (cmd_out !== 1'b1 || cmd_oe !== 1'b0 || cmd_strobe !== 1'b0 || cmd_index !== 6'd0 ||
            cmd_arg !== 32'd0 || crc_error !== 1'b0 || resp_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: out=%b oe=%b strobe=%b idx=%h arg=%h err=%b ack=%b, required 1 0 0 0 0 0 0",
                     cmd_out, cmd_oe, cmd_strobe, cmd_index, cmd_arg, crc_error, resp_ack);
        end
        reset = 1'b1;
        exp_index = 6'd0;
        exp_arg   = 32'd0;
        repeat (3) @(negedge sd_clock);
        checks++;
        if (cmd_oe !== 1'b0 || cmd_out !== 1'b1 || cmd_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: oe=%b out=%b strobe=%b, required 0 1 0", cmd_oe, cmd_out, cmd_strobe);
        end
    endtask

    task automatic test_cmd0();
        logic [135:0] got;
        recv_frame(48'h400000000095, "cmd0");
        respond(0, '0, 1, "cmd0", got);
    endtask

    task automatic test_cmd8();
        logic [135:0] got;
        recv_frame(48'h48000001AA87, "cmd8");
        checks++;
        if (exp_index !== 6'd8 || exp_arg !== 32'h000001AA) begin
            errors++;
            $display("FAIL cmd8_frame: reference decoded idx=%h arg=%h, required 08 000001aa", exp_index, exp_arg);
        end
        respond(0, '0, 0, "cmd8", got);
    endtask

    task automatic test_bad_crc();
        recv_frame(48'h48000001AA85, "bad_crc");
        recv_frame(48'h48000001AA86, "bad_end");
        recv_frame(48'h08000001AA87, "bad_txbit");
    endtask

    task automatic test_cmd17_short();
        logic [135:0] got;
        logic [135:0] data;
        logic [47:0] want;
        want = 48'h110000090067;
        data = '0;
        data[47:8] = 40'h1100000900;
        recv_frame(48'h510000000055, "cmd17");
        respond(1, data, 2, "cmd17", got);
        checks++;
        if (got[47:0] !== want) begin
            errors++;
            $display("FAIL cmd17_r1: serialized %h, required %h", got[47:0], want);
        end
    endtask

    task automatic test_long();
        logic [135:0] got;
        logic [135:0] data;
        data = {8'h3F, {16{8'hA5}}};
        recv_frame(make_frame(6'd2, $urandom), "r2");
        respond(2, data, 1, "r2", got);
    endtask

    task automatic test_reset_mid_send();
        int oe_hi;
        oe_hi = 0;
        recv_frame(make_frame(6'd17, $urandom), "rst_send");
        resp_valid = 1'b1;
        resp_none  = 1'b0;
        resp_long  = 1'b0;
        resp_data  = {8'($urandom), $urandom, $urandom, $urandom, $urandom};
        @(negedge sd_clock);
        resp_valid = 1'b0;
        repeat (NCR_TB + 21) @(negedge sd_clock);
        checks++;
        if (cmd_oe !== 1'b1) begin
            errors++;
            $display("FAIL rst_send_active: oe=%b at response bit 20, required 1", cmd_oe);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (cmd_oe !== 1'b0 || cmd_out !== 1'b1 || cmd_strobe !== 1'b0 || cmd_index !== 6'd0 || cmd_arg !== 32'd0) begin
            errors++;
            $display("FAIL rst_send_async: oe=%b out=%b strobe=%b idx=%h arg=%h, required 0 1 0 0 0",
                     cmd_oe, cmd_out, cmd_strobe, cmd_index, cmd_arg);
        end
        @(negedge sd_clock);
        reset = 1'b1;
        exp_index = 6'd0;
        exp_arg   = 32'd0;
        repeat (60) begin
            @(negedge sd_clock);
            if (cmd_oe !== 1'b0) oe_hi++;
        end
        checks++;
        if (oe_hi != 0) begin
            errors++;
            $display("FAIL rst_send_after: oe high %0d cycles after reset, required 0", oe_hi);
        end
    endtask

    task automatic test_abort_recv();
        logic [47:0] f;
        logic [135:0] got;
        int seen;
        seen = 0;
        f = make_frame(6'($urandom), $urandom);
        for (int i = 47; i >= 28; i--) begin
            @(negedge sd_clock);
            cmd_in = f[i];
        end
        @(negedge sd_clock);
        cmd_in = 1'b1;
        abort  = 1'b1;
        @(negedge sd_clock);
        abort = 1'b0;
        repeat (60) begin
            @(negedge sd_clock);
            if (cmd_strobe !== 1'b0 || crc_error !== 1'b0 || cmd_oe !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_recv: %0d cycles with strobe/err/oe after abort, required 0", seen);
        end
        recv_frame(make_frame(6'($urandom), $urandom), "abort_next");
        respond(1, {8'($urandom), $urandom, $urandom, $urandom, $urandom}, 0, "abort_next", got);
    endtask

    task automatic test_abort_notify();
        int seen;
        seen = 0;
        recv_frame(make_frame(6'd13, $urandom), "abort_ntf");
        abort      = 1'b1;
        resp_valid = 1'b1;
        resp_none  = 1'b0;
        resp_long  = 1'b0;
        @(negedge sd_clock);
        checks++;
        if (resp_ack !== 1'b0 || cmd_strobe !== 1'b0) begin
            errors++;
            $display("FAIL abort_ntf_ack: ack=%b strobe=%b, required 0 0", resp_ack, cmd_strobe);
        end
        abort      = 1'b0;
        resp_valid = 1'b0;
        repeat (60) begin
            @(negedge sd_clock);
            if (cmd_oe !== 1'b0 || resp_ack !== 1'b0 || cmd_strobe !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_ntf_quiet: %0d active cycles after abort, required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [47:0] f;
        logic [135:0] got;
        for (int n = 0; n < 10; n++) begin
            f = make_frame(6'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) f = f ^ (48'd1 << $urandom_range(0, 46));
            recv_frame(f, "rand");
            if (frame_ok_ref(f)) begin
                respond(int'($urandom_range(0, 2)), {8'($urandom), $urandom, $urandom, $urandom, $urandom},
                        int'($urandom_range(0, 3)), "rand", got);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        abort      = 1'b0;
        cmd_in     = 1'b1;
        resp_valid = 1'b0;
        resp_none  = 1'b0;
        resp_long  = 1'b0;
        resp_data  = '0;
        exp_index  = 6'd0;
        exp_arg    = 32'd0;
        test_reset();
        test_cmd0();
        test_cmd8();
        test_bad_crc();
        test_cmd17_short();
        test_long();
        test_reset_mid_send();
        test_abort_recv();
        test_abort_notify();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
